loader_write_queue: RTL and testbench
=====================================

Name: loader_write_queue

Overview:
- Downstream of the ROM/BIOS/FDS/NSF game loader; sits between the loader's byte-write strobe stream and the SDRAM controller's 16-bit write port.
- Buffers byte writes in a small FIFO, converts each to a 16-bit word access with byte select, and issues them over a req/ack handshake.
- Reports drain-complete (idle) so top level can hold the core in reset until every loaded byte is committed; flags overflow since the loader has no backpressure.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64
- ADDR_W, 22, byte address width from loader
- GAP, 1, idle cycles forced between ack and next req (0..3)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  pulse; clears overflow flag and level_max (FIFO contents untouched)
- wr_en  in  1  one-cycle write strobe from loader
- wr_addr  in  ADDR_W  byte address
- wr_data  in  8  byte data
- mem_req  out  1  write request, held until ack
- mem_addr  out  ADDR_W-1  word address (wr_addr[ADDR_W-1:1])
- mem_din  out  16  {byte,byte} duplicated
- mem_ds  out  2  byte select: addr[0]=0 -> 2'b01 (low), 1 -> 2'b10 (high)
- mem_ack  in  1  one-cycle acknowledge from SDRAM controller
- idle  out  1  FIFO empty and no transaction outstanding
- overflow  out  1  sticky: a write was dropped
- level  out  $clog2(DEPTH)+1  current occupancy
- level_max  out  $clog2(DEPTH)+1  high-water mark since reset/start

Behaviour:
- Reset: mem_req=0, mem_addr=0, mem_din=0, mem_ds=0, idle=1, overflow=0, level=0, level_max=0, pointers=0, state=S_IDLE. Reset mid-transaction drops mem_req the next cycle and discards all entries; a late mem_ack is ignored.
- FIFO: circular, rd/wr pointers $clog2(DEPTH) bits wrapping naturally; count 0..DEPTH.
- Push accepted when wr_en and (count<DEPTH or a pop occurs in the same cycle). Otherwise the byte is dropped and overflow set at next edge.
- Simultaneous push+pop: count unchanged, both pointers advance; valid at full and at count=1.
- level_max <= max(level_max, next count) each cycle; start and a same-cycle push: clear takes priority, then level_max = next count.
- FSM (registered outputs):
  - S_IDLE: if count!=0, load mem_addr/mem_din/mem_ds from head entry, mem_req<=1 -> S_ISSUE.
  - S_ISSUE: hold outputs stable; on mem_ack: pop head, mem_req<=0 -> S_GAP (GAP>0) else S_IDLE.
  - S_GAP: count GAP cycles -> S_IDLE.
- Latency: byte pushed at edge N (FIFO empty, S_IDLE) -> mem_req high after edge N+1. Ack at edge M -> mem_req low after M; with GAP=1, next req after M+2.
- mem_ack outside S_ISSUE ignored. mem_ack in the same cycle req is first asserted is not possible (req registered), so it is not special-cased.
- idle = (count==0) && state==S_IDLE, combinational from registers. It is 0 during S_GAP.
- Ordering strictly FIFO; no write coalescing (two bytes of one word issue as two accesses).
- start does not abort or flush; the overflow clear takes priority over a same-cycle drop.

Decomposition:
- Shared package loader_pkg: state enum (S_IDLE, S_ISSUE, S_GAP), byte-select constants DS_LO=2'b01 / DS_HI=2'b10, and entry struct {addr, data}.
- One sub-module: loader_fifo (storage, pointers, count, full/empty, push/pop with simultaneous-op handling).
- The top contains the FSM, byte-lane mapping, and overflow/level_max tracking.

Test Plan:
- Single write wr_addr=0x000011, data=0xA5, ack 3 cycles after req -> one req with mem_addr=0x000008, mem_din=0xA5A5, mem_ds=2'b10; idle returns 1 GAP+1 cycles after ack.
- Burst of 8 strobes on consecutive cycles, ack held off 20 cycles -> level reaches 8, level_max=8, overflow=0; writes drain in order with correct ds alternation.
- 9 back-to-back strobes with no ack -> 9th dropped, overflow=1, level=8; pulse start -> overflow=0, level_max=8 (current count).
- At full, push coincident with ack -> push accepted, level stays 8, overflow stays 0, data order preserved.
- Reset asserted while mem_req=1 with 5 entries -> mem_req=0 next cycle, level=0, idle=1; ack pulse one cycle later produces no pop and no new req.
- Random strobe stream (1000 bytes, 30% density) with random 1-6 cycle ack delay -> scoreboard matches every address/data/ds; idle=1 only when empty.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types for the loader write queue.
//   state_t  : write-issue FSM states
//   DS_LO/HI : SDRAM byte-select codes for the low/high byte lane
//   entry_t  : one buffered loader write {addr, data}; addr is sized for the
//              widest supported loader address and zero-extended on push
package loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [1:0] DS_LO = 2'b01;
  localparam logic [1:0] DS_HI = 2'b10;

  localparam int ENTRY_ADDR_W = 32;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [7:0]              data;
  } entry_t;

  // Byte address bit 0 picks the lane inside the 16-bit SDRAM word.
  function automatic logic [1:0] lane_sel(input logic addr_lsb);
    return addr_lsb ? DS_HI : DS_LO;
  endfunction

endpackage

// File: rtl/loader_fifo.sv
// Circular FIFO of loader write entries.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (pointers/count)
//   push_i          : request to store push_data_i
//   pop_i           : discard head entry (ignored when empty)
//   push_data_i     : entry to store
//   head_o          : oldest entry, valid when !empty_o
//   push_ok_o       : push_i was accepted this cycle
//   empty_o         : no entries stored
//   count_o         : current occupancy 0..DEPTH
//   count_d_o       : occupancy after this clock edge
module loader_fifo
  import loader_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  entry_t           push_data_i,
  output entry_t           head_o,
  output logic             push_ok_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] count_d_o
);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           mem_q [DEPTH];
  logic             full, do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot being written, so a full FIFO
  // still accepts.
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign push_ok_o = do_push;
  assign count_o   = count_q;
  assign count_d_o = count_d;

endmodule

// File: rtl/loader_write_queue.sv
// Buffers loader byte writes and issues them as 16-bit SDRAM word writes
// with byte select over a req/ack handshake.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : pulse, clears overflow and level_max
//   wr_en/addr/data     : loader byte-write strobe (no backpressure)
//   mem_req             : write request, held until mem_ack
//   mem_addr            : word address (byte address >> 1)
//   mem_din             : byte duplicated on both lanes
//   mem_ds              : byte select, 01 low lane / 10 high lane
//   mem_ack             : one-cycle acknowledge
//   idle                : nothing buffered and no access in flight
//   overflow            : sticky, a write was dropped
//   level, level_max    : occupancy and high-water mark
//
// state   | meaning
// S_IDLE  | no access in flight; launch head entry when FIFO non-empty
// S_ISSUE | mem_req held with stable address/data until mem_ack
// S_GAP   | enforced quiet cycles after an ack before the next request
module loader_write_queue
  import loader_pkg::*;
#(
  parameter  int DEPTH  = 8,
  parameter  int ADDR_W = 22,
  parameter  int GAP    = 1,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              mem_req,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic [1:0]        mem_ds,
  input  logic              mem_ack,
  output logic              idle,
  output logic              overflow,
  output logic [CNT_W-1:0]  level,
  output logic [CNT_W-1:0]  level_max
);

  localparam logic [1:0] GAP_LOAD = (GAP > 0) ? 2'(GAP - 1) : 2'd0;

  state_t            state_q, state_d;
  logic [1:0]        gap_q, gap_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-2:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_din_q, mem_din_d;
  logic [1:0]        mem_ds_q, mem_ds_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  level_max_q, level_max_d;

  entry_t            push_entry, head;
  logic              pop, push_ok, empty;
  logic [CNT_W-1:0]  count, count_d;
  logic              head_addr_unused;

  always_comb begin
    push_entry      = '0;
    push_entry.addr = ENTRY_ADDR_W'(wr_addr);
    push_entry.data = wr_data;
  end

  loader_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (wr_en),
    .pop_i       (pop),
    .push_data_i (push_entry),
    .head_o      (head),
    .push_ok_o   (push_ok),
    .empty_o     (empty),
    .count_o     (count),
    .count_d_o   (count_d)
  );

  // Bits above ADDR_W are always zero from the zero-extension on push.
  assign head_addr_unused = |(head.addr >> ADDR_W);

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_ds_d   = mem_ds_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          mem_addr_d = head.addr[ADDR_W-1:1];
          mem_din_d  = {head.data, head.data};
          mem_ds_d   = lane_sel(head.addr[0]);
          mem_req_d  = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_ack) begin
          pop       = 1'b1;
          mem_req_d = 1'b0;
          if (GAP > 0) begin
            gap_d   = GAP_LOAD;
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_q == 2'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // start wins over a same-cycle drop, and restarts the high-water mark
  // from the occupancy after this edge.
  always_comb begin
    overflow_d  = overflow_q | (wr_en & ~push_ok);
    level_max_d = (count_d > level_max_q) ? count_d : level_max_q;
    if (start) begin
      overflow_d  = 1'b0;
      level_max_d = count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      gap_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_ds_q    <= '0;
      overflow_q  <= 1'b0;
      level_max_q <= '0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_ds_q    <= mem_ds_d;
      overflow_q  <= overflow_d;
      level_max_q <= level_max_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_ds    = mem_ds_q;
  assign idle      = empty && (state_q == S_IDLE);
  assign overflow  = overflow_q;
  assign level     = count;
  assign level_max = level_max_q;

endmodule

// File: tb/tb_loader_write_queue.sv
module tb_loader_write_queue;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 22;
  localparam int GAP    = 1;

  logic        clk = 1'b0;
  logic        reset, start, wr_en, mem_ack;
  logic [21:0] wr_addr;
  logic [7:0]  wr_data;
  logic        mem_req, idle, overflow;
  logic [20:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_ds;
  logic [3:0]  level, level_max;

  always #5 clk = ~clk;

  loader_write_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP(GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_ds    (mem_ds),
    .mem_ack   (mem_ack),
    .idle      (idle),
    .overflow  (overflow),
    .level     (level),
    .level_max (level_max)
  );

  typedef struct {
    logic [21:0] addr;
    logic [7:0]  data;
    logic [20:0] exp_addr;
    logic [15:0] exp_din;
    logic [1:0]  exp_ds;
  } vec_t;

  typedef struct {
    logic [21:0] addr;
    logic [7:0]  data;
  } sb_t;

  int   total = 0;
  int   bad   = 0;
  sb_t  exp_q[$];
  int   m_count, m_gap, m_lmax;
  bit   m_req, m_over;
  bit   auto_ack;
  int   ack_wait;
  int   ack_lo = 1, ack_hi = 6;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge,
  // compare after the edge, then let the ack responder react.
  task automatic cycle();
    bit  pop, push_ok;
    sb_t e;
    if (reset) begin
      exp_q.delete();
      m_count = 0; m_gap = 0; m_lmax = 0; m_req = 0; m_over = 0;
    end else begin
      pop     = mem_ack && m_req;
      push_ok = wr_en && (m_count < DEPTH || pop);
      if (pop) begin
        if (exp_q.size() == 0) begin
          check("pop_on_empty_model", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("sb_addr", 32'(mem_addr), 32'(e.addr[21:1]));
          check("sb_din",  32'(mem_din),  32'({e.data, e.data}));
          check("sb_ds",   32'(mem_ds),   e.addr[0] ? 32'd2 : 32'd1);
        end
      end
      if (push_ok) exp_q.push_back('{wr_addr, wr_data});
      if (wr_en && !push_ok) m_over = 1;
      if (start) m_over = 0;
      if (m_req) begin
        if (mem_ack) begin m_req = 0; m_gap = GAP; end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (m_count > 0) begin
        m_req = 1;
      end
      m_count = m_count + int'(push_ok) - int'(pop);
      m_lmax  = start ? m_count : ((m_count > m_lmax) ? m_count : m_lmax);
    end
    @(posedge clk);
    #1;
    check("mem_req",   32'(mem_req),   32'(m_req));
    check("idle",      32'(idle),      32'(m_count == 0 && !m_req && m_gap == 0));
    check("overflow",  32'(overflow),  32'(m_over));
    check("level",     32'(level),     32'(m_count));
    check("level_max", 32'(level_max), 32'(m_lmax));
    if (auto_ack) begin
      if (mem_ack) begin
        mem_ack  = 0;
        ack_wait = $urandom_range(ack_hi, ack_lo);
      end else if (mem_req) begin
        if (ack_wait <= 1) mem_ack = 1;
        else ack_wait--;
      end
    end
  endtask

  task automatic strobe(input logic [21:0] a, input logic [7:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    cycle();
    wr_en = 0;
  endtask

  task automatic wait_req(input int maxc);
    int n = 0;
    while (!mem_req && n < maxc) begin cycle(); n++; end
    check("req_timeout", 32'(mem_req), 32'd1);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (!(idle && exp_q.size() == 0) && n < maxc) begin cycle(); n++; end
    check("drain_idle", 32'(idle), 32'd1);
    check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{22'h000011, 8'hA5, 21'h000008, 16'hA5A5, 2'b10};
    vecs[1] = '{22'h000000, 8'h3C, 21'h000000, 16'h3C3C, 2'b01};
    vecs[2] = '{22'h3FFFFF, 8'hFF, 21'h1FFFFF, 16'hFFFF, 2'b10};
    vecs[3] = '{22'h3FFFFE, 8'h01, 21'h1FFFFF, 16'h0101, 2'b01};
    vecs[4] = '{22'h155554, 8'h5A, 21'h0AAAAA, 16'h5A5A, 2'b01};
    vecs[5] = '{22'h2AAAAB, 8'hC3, 21'h155555, 16'hC3C3, 2'b10};

    reset = 1; start = 0; wr_en = 0; mem_ack = 0; wr_addr = '0; wr_data = '0;
    auto_ack = 0; ack_wait = 3;
    m_count = 0; m_gap = 0; m_lmax = 0; m_req = 0; m_over = 0;
    repeat (3) cycle();
    reset = 0;
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_din",  32'(mem_din),  32'd0);
    check("rst_ds",   32'(mem_ds),   32'd0);
    check("rst_idle", 32'(idle),     32'd1);

    // Single writes: lane mapping, one-cycle launch latency, ack 3 cycles on.
    for (int i = 0; i < 6; i++) begin
      strobe(vecs[i].addr, vecs[i].data);
      check("t1_no_req_yet", 32'(mem_req), 32'd0);
      cycle();
      check("t1_req_latency", 32'(mem_req), 32'd1);
      check("t1_addr", 32'(mem_addr), 32'(vecs[i].exp_addr));
      check("t1_din",  32'(mem_din),  32'(vecs[i].exp_din));
      check("t1_ds",   32'(mem_ds),   32'(vecs[i].exp_ds));
      cycle(); cycle();
      mem_ack = 1;
      cycle();
      mem_ack = 0;
      check("t1_req_drop", 32'(mem_req), 32'd0);
      check("t1_gap_not_idle", 32'(idle), 32'd0);
      cycle();
      check("t1_idle_back", 32'(idle), 32'd1);
    end

    // Burst of 8, ack held off.
    for (int i = 0; i < 8; i++) strobe(22'h001000 + 22'(i), 8'(8'h10 + i));
    repeat (20) cycle();
    check("t2_level", 32'(level), 32'd8);
    check("t2_lmax", 32'(level_max), 32'd8);
    check("t2_ovf", 32'(overflow), 32'd0);
    auto_ack = 1; ack_lo = 1; ack_hi = 3; ack_wait = 2;
    drain(200);
    auto_ack = 0;

    // Nine strobes, no ack: ninth dropped; start clears overflow only.
    for (int i = 0; i < 9; i++) strobe(22'h002000 + 22'(i), 8'(8'h80 + i));
    check("t3_level", 32'(level), 32'd8);
    check("t3_ovf", 32'(overflow), 32'd1);
    start = 1;
    cycle();
    start = 0;
    check("t3_ovf_clr", 32'(overflow), 32'd0);
    check("t3_lmax", 32'(level_max), 32'd8);

    // At full, push coincident with ack is accepted.
    check("t4_req_before", 32'(mem_req), 32'd1);
    mem_ack = 1; wr_en = 1; wr_addr = 22'h003333; wr_data = 8'h77;
    cycle();
    mem_ack = 0; wr_en = 0;
    check("t4_level", 32'(level), 32'd8);
    check("t4_ovf", 32'(overflow), 32'd0);
    auto_ack = 1; ack_wait = 2;
    drain(200);
    auto_ack = 0;

    // Reset mid-transaction, then a late ack.
    for (int i = 0; i < 5; i++) strobe(22'h004000 + 22'(2 * i), 8'(i));
    check("t5_req_up", 32'(mem_req), 32'd1);
    reset = 1;
    cycle();
    reset = 0;
    check("t5_req_gone", 32'(mem_req), 32'd0);
    check("t5_level", 32'(level), 32'd0);
    check("t5_idle", 32'(idle), 32'd1);
    mem_ack = 1;
    cycle();
    mem_ack = 0;
    cycle(); cycle();
    check("t5_no_req", 32'(mem_req), 32'd0);
    check("t5_level_after", 32'(level), 32'd0);

    // Random stream with random ack delay.
    auto_ack = 1; ack_lo = 1; ack_hi = 6; ack_wait = 2;
    begin
      int sent = 0;
      int cyc  = 0;
      while (sent < 1000 && cyc < 20000) begin
        wr_en = ($urandom_range(0, 99) < 30);
        if (wr_en) begin
          wr_addr = 22'($urandom);
          wr_data = 8'($urandom);
          sent++;
        end
        start = ($urandom_range(0, 199) == 0);
        cycle();
        cyc++;
      end
      wr_en = 0; start = 0;
      check("t6_sent", 32'(sent), 32'd1000);
    end
    drain(500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
